prbs31_checker: RTL and testbench



---
 rtl/prbs31_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_prbs31_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// ============================================================================
// prbs31_checker
// ----------------------------------------------------------------------------
// Receive-side PRBS31 (x^31 + x^28 + 1) checker. It consumes a qualified
// serial bit stream and self-synchronises by loading the last 31 received
// bits into a history register. It then requires a run of consecutive
// correctly predicted bits before it declares lock. While locked it counts
// checked bits and mismatches. It monitors the error density in fixed windows
// of WIN_LEN valid bits and drops back to hunting when a window is too noisy.
//
// Ports:
//   clk             in   system clock, all logic on the rising edge
//   rst             in   asynchronous active-high reset
//   clear           in   synchronous clear of the three statistics counters
//                        (does not change the lock state)
//   in_valid        in   qualifies in_bit; nothing changes while it is low
//   in_bit          in   received serial bit
//   locked          out  registered, high while the checker is locked
//   err_pulse       out  registered one-cycle strobe per mismatch while locked
//   err_count       out  saturating mismatch count while locked (CNT_W bits)
//   bit_count       out  saturating count of bits checked while locked
//   sync_loss_count out  saturating count of lock losses
// ============================================================================
module prbs31_checker #(
    parameter int LOCK_COUNT = 64,
    parameter int WIN_LEN    = 128,
    parameter int ERR_THRESH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      bit_count,
    output logic [7:0]       sync_loss_count
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int WBIT_W = $clog2(WIN_LEN + 1);
    localparam int WERR_W = $clog2(WIN_LEN + 1);

    localparam logic [4:0]        FILL_LAST = 5'd30;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WBIT_W-1:0] WIN_LAST  = WBIT_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [30:0]         hist_q, hist_d;
    logic [4:0]          fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [WBIT_W-1:0]   win_bits_q, win_bits_d;
    logic [WERR_W-1:0]   win_errs_q, win_errs_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [31:0]         bit_count_q, bit_count_d;
    logic [7:0]          sync_loss_q, sync_loss_d;

    logic                pred;
    logic                mismatch;
    logic                count_bit;
    logic                count_err;
    logic                window_fail;
    logic [WERR_W-1:0]   win_errs_total;

    // The prediction always uses the history as it stood before this bit
    // arrived. An all-zero history is treated as a mismatch so that a line
    // stuck at 0 (which trivially satisfies the recurrence) can never lock.
    always_comb begin
        pred     = hist_q[30] ^ hist_q[27];
        mismatch = (in_bit != pred) || (hist_q == '0);
        hist_d   = hist_q;
        if (in_valid) begin
            hist_d = {hist_q[29:0], in_bit};
        end
    end

    // Lock state machine. HUNT only fills the history; TRAIN demands an
    // unbroken run of matches; LOCKED checks bits and judges each window on
    // its final bit, counting that bit's own error in the decision. A failed
    // window keeps the history and restarts the fill count from zero.
    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        run_d          = run_q;
        win_bits_d     = win_bits_q;
        win_errs_d     = win_errs_q;
        count_bit      = 1'b0;
        count_err      = 1'b0;
        window_fail    = 1'b0;
        win_errs_total = win_errs_q + WERR_W'(mismatch);

        case (state_q)
            ST_HUNT: begin
                if (in_valid) begin
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_TRAIN;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
            end

            ST_TRAIN: begin
                if (in_valid) begin
                    if (mismatch) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d    = ST_LOCKED;
                        run_d      = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
            end

            ST_LOCKED: begin
                if (in_valid) begin
                    count_bit = 1'b1;
                    count_err = mismatch;
                    if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                        if (32'(win_errs_total) >= 32'(ERR_THRESH)) begin
                            state_d     = ST_HUNT;
                            fill_d      = '0;
                            window_fail = 1'b1;
                        end
                    end else begin
                        win_bits_d = win_bits_q + WBIT_W'(1);
                        win_errs_d = win_errs_total;
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
                fill_d  = '0;
                run_d   = '0;
            end
        endcase
    end

    // Registered status outputs. locked follows the next state so that it
    // changes on the same edge that moves the FSM into or out of LOCKED.
    always_comb begin
        locked_d    = (state_d == ST_LOCKED);
        err_pulse_d = count_err;
    end

    // Statistics counters. They saturate at all-ones, and a clear in the same
    // cycle as an increment takes priority so the counter reads zero.
    always_comb begin
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        sync_loss_d = sync_loss_q;
        if (clear) begin
            err_count_d = '0;
            bit_count_d = '0;
            sync_loss_d = '0;
        end else begin
            if (count_err && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            if (count_bit && (bit_count_q != '1)) begin
                bit_count_d = bit_count_q + 32'd1;
            end
            if (window_fail && (sync_loss_q != '1)) begin
                sync_loss_d = sync_loss_q + 8'd1;
            end
        end
    end

    // All state lives in this single register bank, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            hist_q      <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
            sync_loss_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign locked          = locked_q;
    assign err_pulse       = err_pulse_q;
    assign err_count       = err_count_q;
    assign bit_count       = bit_count_q;
    assign sync_loss_count = sync_loss_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// ============================================================================
// tb_prbs31_checker
// ----------------------------------------------------------------------------
// Self-checking bench for prbs31_checker. A driver issues one stimulus per
// clock and pushes the expected registered outputs (from a bit-history
// reference model) into a queue; a monitor pops and compares after each
// rising edge. err_count is built narrow here so its saturation is reachable.
// ============================================================================
module tb_prbs31_checker;

    localparam int CW         = 4;
    localparam int LOCK_COUNT = 64;
    localparam int WIN_LEN    = 128;
    localparam int ERR_THRESH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [31:0]   bit_count;
    logic [7:0]    sync_loss_count;

    prbs31_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .WIN_LEN   (WIN_LEN),
        .ERR_THRESH(ERR_THRESH),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_bit         (in_bit),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .err_count      (err_count),
        .bit_count      (bit_count),
        .sync_loss_count(sync_loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          locked;
        logic          err_pulse;
        logic [CW-1:0] err_count;
        logic [31:0]   bit_count;
        logic [7:0]    sync_loss;
        int            vidx;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int failures = 0;

    bit    rxBits[$];
    int    mMode;
    int    mFill;
    int    mRun;
    int    mWinBits;
    int    mWinErrs;
    int    mErr;
    longint mBits;
    int    mSync;
    int    validIdx;

    logic [30:0] genState;

    int  lockIdx;
    bit  prevLocked;
    bit  everLocked;
    int  pulseIdx[$];

    // Reference model reset: forget all received bits and statistics.
    task automatic modelReset();
        rxBits.delete();
        mMode    = 0;
        mFill    = 0;
        mRun     = 0;
        mWinBits = 0;
        mWinErrs = 0;
        mErr     = 0;
        mBits    = 0;
        mSync    = 0;
        validIdx = 0;
    endtask

    // Reference model step. The received-bit list gives the prediction
    // directly from the recurrence b[n] = b[n-31] ^ b[n-28], with bits
    // before reset taken as zero.
    task automatic modelStep(input bit v, input bit b, input bit c);
        exp_t e;
        int   n;
        bit   b31;
        bit   b28;
        bit   allZero;
        bit   miss;
        bit   pulse;
        bit   errInc;
        bit   bitInc;
        bit   syncInc;
        pulse   = 1'b0;
        errInc  = 1'b0;
        bitInc  = 1'b0;
        syncInc = 1'b0;
        if (v) begin
            validIdx++;
            n   = rxBits.size();
            b31 = (n >= 31) ? rxBits[n-31] : 1'b0;
            b28 = (n >= 28) ? rxBits[n-28] : 1'b0;
            allZero = 1'b1;
            for (int k = 1; k <= 31; k++) begin
                if (n >= k && rxBits[n-k]) allZero = 1'b0;
            end
            miss = (b != (b31 ^ b28)) || allZero;
            if (mMode == 0) begin
                mFill++;
                if (mFill == 31) begin
                    mMode = 1;
                    mRun  = 0;
                end
            end else if (mMode == 1) begin
                if (miss) mRun = 0;
                else      mRun++;
                if (mRun == LOCK_COUNT) begin
                    mMode    = 2;
                    mWinBits = 0;
                    mWinErrs = 0;
                end
            end else begin
                bitInc = 1'b1;
                if (miss) begin
                    errInc = 1'b1;
                    pulse  = 1'b1;
                    mWinErrs++;
                end
                mWinBits++;
                if (mWinBits == WIN_LEN) begin
                    if (mWinErrs >= ERR_THRESH) begin
                        mMode   = 0;
                        mFill   = 0;
                        syncInc = 1'b1;
                    end
                    mWinBits = 0;
                    mWinErrs = 0;
                end
            end
            rxBits.push_back(b);
            if (rxBits.size() > 48) void'(rxBits.pop_front());
        end
        if (c) begin
            mErr  = 0;
            mBits = 0;
            mSync = 0;
        end else begin
            if (errInc && mErr < (1 << CW) - 1) mErr++;
            if (bitInc && mBits < 64'hFFFF_FFFF) mBits++;
            if (syncInc && mSync < 255) mSync++;
        end
        e.locked    = (mMode == 2);
        e.err_pulse = pulse;
        e.err_count = CW'(mErr);
        e.bit_count = mBits[31:0];
        e.sync_loss = 8'(mSync);
        e.vidx      = validIdx;
        expQ.push_back(e);
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Compares one popped expectation and records lock and pulse positions.
    task automatic checkOutput(input exp_t e);
        compareField("locked", 32'(locked), 32'(e.locked));
        compareField("err_pulse", 32'(err_pulse), 32'(e.err_pulse));
        compareField("err_count", 32'(err_count), 32'(e.err_count));
        compareField("bit_count", bit_count, e.bit_count);
        compareField("sync_loss_count", 32'(sync_loss_count), 32'(e.sync_loss));
        if (locked === 1'b1 && !prevLocked) lockIdx = e.vidx;
        if (locked === 1'b1) everLocked = 1'b1;
        prevLocked = (locked === 1'b1);
        if (err_pulse === 1'b1) pulseIdx.push_back(e.vidx);
    endtask

    // Monitor: after each rising edge, pop and compare the expected outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input bit v, input bit b, input bit c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clear    = c;
        modelStep(v, b, c);
    endtask

    task automatic genBit(output bit b);
        b = genState[30] ^ genState[27];
        genState = {genState[29:0], b};
    endtask

    task automatic sendPrbs(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            genBit(b);
            applyStimulus(1'b1, b, 1'b0);
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        compareField({tag, "_locked"}, 32'(locked), 32'd0);
        compareField({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        compareField({tag, "_err_count"}, 32'(err_count), 32'd0);
        compareField({tag, "_bit_count"}, bit_count, 32'd0);
        compareField({tag, "_sync_loss"}, 32'(sync_loss_count), 32'd0);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        expQ.delete();
        lockIdx    = -1;
        prevLocked = 1'b0;
        everLocked = 1'b0;
        pulseIdx.delete();
        rst = 1'b0;
        #1;
        checkAllZero("reset");
    endtask

    initial begin
        int base;
        bit b;

        // Lock acquisition from seed 1 and 1000 checked bits
        doReset();
        genState = 31'd1;
        sendPrbs(95);
        drain();
        compareField("lock_index", 32'(lockIdx), 32'd95);
        sendPrbs(1000);
        drain();
        compareField("bit_count_1000", bit_count, 32'd1000);
        compareField("err_count_clean", 32'(err_count), 32'd0);

        // Single flipped line bit
        pulseIdx.delete();
        base = validIdx;
        genBit(b);
        applyStimulus(1'b1, ~b, 1'b0);
        sendPrbs(40);
        drain();
        compareField("pulse_total", 32'(pulseIdx.size()), 32'd3);
        if (pulseIdx.size() == 3) begin
            compareField("pulse_off0", 32'(pulseIdx[0] - base), 32'd1);
            compareField("pulse_off28", 32'(pulseIdx[1] - base), 32'd29);
            compareField("pulse_off31", 32'(pulseIdx[2] - base), 32'd32);
        end
        compareField("err_count_3", 32'(err_count), 32'd3);
        compareField("locked_after_err", 32'(locked), 32'd1);

        // Clear coincident with a counted bit
        genBit(b);
        applyStimulus(1'b1, b, 1'b1);
        drain();
        compareField("clear_err", 32'(err_count), 32'd0);
        compareField("clear_bits", bit_count, 32'd0);
        compareField("clear_locked", 32'(locked), 32'd1);

        // Lock loss on a random window, then relock
        while (mWinBits != 0) sendPrbs(1);
        for (int i = 0; i < WIN_LEN; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)),
                          (i < 100) && ($urandom_range(0, 31) == 0));
        end
        drain();
        compareField("loss_locked", 32'(locked), 32'd0);
        compareField("loss_count", 32'(sync_loss_count), 32'd1);
        lockIdx = -1;
        base = validIdx;
        sendPrbs(94);
        drain();
        compareField("relock_early", 32'(locked), 32'd0);
        sendPrbs(1);
        drain();
        compareField("relock_index", 32'(lockIdx - base), 32'd95);

        // Asynchronous reset between clock edges
        sendPrbs(50);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        doReset();

        // Stuck-at-0 line
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        drain();
        compareField("stuck_ever_locked", 32'(everLocked), 32'd0);
        checkAllZero("stuck");

        // Valid gaps with random idle bursts
        doReset();
        genState = 31'd1;
        while (validIdx < 295) begin
            genBit(b);
            applyStimulus(1'b1, b, 1'b0);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        drain();
        compareField("gap_lock_index", 32'(lockIdx), 32'd95);
        compareField("gap_err_count", 32'(err_count), 32'd0);
        compareField("gap_bit_count", bit_count, 32'd200);

        compareField("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
